// File: rtl/fpu16_pkg.sv
// Shared FP16 format constants, flag encodings and divider FSM states.
// Used by the FPU16 add/sub unit and the sequential divider.
package fpu16_pkg;

  localparam int EXP_W     = 5;
  localparam int MAN_W     = 10;
  localparam int BIAS      = 15;
  localparam int EXP_MAX   = 31;
  localparam int E_W       = EXP_W + 2;   // signed exponent width
  localparam int DIV_STEPS = MAN_W + 2;   // quotient bits incl. integer bit

  localparam logic [14:0] INF_MAG = 15'h7C00;
  localparam logic [15:0] QNAN    = 16'h7E00;

  typedef enum logic [1:0] {
    OFUF_OK = 2'b00,
    OFUF_UF = 2'b01,
    OFUF_OF = 2'b10
  } ofuf_e;

  typedef enum logic [1:0] {
    IDLE,
    SPECIAL,
    DIVIDE,
    NORM
  } state_e;

endpackage

// File: rtl/fp16_mant_divider.sv
// Restoring mantissa divider: one quotient bit per step, MSB first.
// quot_o[MAN_W+1] is the integer bit of the ratio, which lies in [0.5, 2).
module fp16_mant_divider
  import fpu16_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [MAN_W-1:0] xm_i,
  input  logic [MAN_W-1:0] ym_i,
  output logic [MAN_W+1:0] quot_o,
  output logic             last_step_o
);

  localparam int REM_W = MAN_W + 3;
  localparam int CNT_W = $clog2(DIV_STEPS + 1);

  logic [REM_W-1:0] rem_q, rem_d;
  logic [MAN_W:0]   divisor_q, divisor_d;
  logic [MAN_W+1:0] quot_q, quot_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [REM_W-1:0] diff;
  logic             ge;

  assign diff = rem_q - {2'b00, divisor_q};
  assign ge   = (rem_q >= {2'b00, divisor_q});

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    rem_d     = rem_q;
    divisor_d = divisor_q;
    quot_d    = quot_q;
    count_d   = count_q;
    if (load_i) begin
      rem_d     = {2'b00, 1'b1, xm_i};
      divisor_d = {1'b1, ym_i};
      quot_d    = '0;
      count_d   = '0;
    end else if (step_i) begin
      rem_d   = ge ? {diff[REM_W-2:0], 1'b0} : {rem_q[REM_W-2:0], 1'b0};
      quot_d  = {quot_q[MAN_W:0], ge};
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is only ever written with non-blocking assignments.
    if (reset) begin
      rem_q     <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      count_q   <= '0;
    end else begin
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      quot_q    <= quot_d;
      count_q   <= count_d;
    end
  end

  assign quot_o      = quot_q;
  assign last_step_o = step_i && (count_q == CNT_W'(DIV_STEPS - 1));

endmodule

// File: rtl/fp16_div_seq.sv
// Multi-cycle FP16 divider (truncating, no subnormals) with start/busy/done handshake.
// Holds the control FSM, exponent path, normalisation and flag logic.
module fp16_div_seq
  import fpu16_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [1:0]  ofuf,
  output logic        div_by_zero
);

  state_e                state_q;
  logic                  busy_q, done_q, dbz_q;
  logic [15:0]           result_q;
  ofuf_e                 ofuf_q;
  logic                  sign_q, x_zero_q, y_zero_q;
  logic signed [E_W-1:0] exp_q;

  logic                  accept, x_zero, y_zero, last_step;
  logic [E_W-1:0]        exp_diff;
  logic [MAN_W+1:0]      quot;

  assign accept   = (state_q == IDLE) && start;
  // A zero operand is recognised by its exponent field alone.
  assign x_zero   = (x[MAN_W +: EXP_W] == '0);
  assign y_zero   = (y[MAN_W +: EXP_W] == '0);
  assign exp_diff = E_W'(x[MAN_W +: EXP_W]) - E_W'(y[MAN_W +: EXP_W]) + E_W'(BIAS);

  fp16_mant_divider u_mant_div (
    .clk         (clk),
    .reset       (reset),
    .load_i      (accept),
    .step_i      (state_q == DIVIDE),
    .xm_i        (x[MAN_W-1:0]),
    .ym_i        (y[MAN_W-1:0]),
    .quot_o      (quot),
    .last_step_o (last_step)
  );

  logic signed [E_W-1:0] en;
  logic [MAN_W-1:0]      frac;
  logic [15:0]           norm_result_d, special_result_d;
  ofuf_e                 norm_ofuf_d;

  always_comb begin
    frac = quot[MAN_W+1] ? quot[MAN_W:1] : quot[MAN_W-1:0];
    en   = quot[MAN_W+1] ? exp_q : exp_q - E_W'(1);
    norm_result_d = {sign_q, en[EXP_W-1:0], frac};
    norm_ofuf_d   = OFUF_OK;
    if (en >= E_W'(EXP_MAX)) begin
      norm_result_d = {sign_q, INF_MAG};
      norm_ofuf_d   = OFUF_OF;
    end else if (en <= E_W'(0)) begin
      norm_result_d = {sign_q, 15'h0000};
      norm_ofuf_d   = OFUF_UF;
    end
  end

  always_comb begin
    special_result_d = {sign_q, 15'h0000};
    if (y_zero_q) special_result_d = x_zero_q ? QNAN : {sign_q, INF_MAG};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ofuf_q   <= OFUF_OK;
      dbz_q    <= 1'b0;
      sign_q   <= 1'b0;
      x_zero_q <= 1'b0;
      y_zero_q <= 1'b0;
      exp_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          busy_q <= start;
          if (start) begin
            ofuf_q   <= OFUF_OK;
            dbz_q    <= 1'b0;
            sign_q   <= x[15] ^ y[15];
            x_zero_q <= x_zero;
            y_zero_q <= y_zero;
            exp_q    <= $signed(exp_diff);
            state_q  <= (x_zero || y_zero) ? SPECIAL : DIVIDE;
          end
        end
        SPECIAL: begin
          result_q <= special_result_d;
          dbz_q    <= y_zero_q;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        DIVIDE: begin
          if (last_step) state_q <= NORM;
        end
        NORM: begin
          result_q <= norm_result_d;
          ofuf_q   <= norm_ofuf_d;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign ofuf        = ofuf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp16_div_seq.sv
// Scoreboard bench for fp16_div_seq: issued operations push the expected response,
// a monitor pops and compares on every done pulse.
module tb_fp16_div_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] x, y;
  logic        busy, done, div_by_zero;
  logic [15:0] result;
  logic [1:0]  ofuf;

  fp16_div_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .x           (x),
    .y           (y),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .ofuf        (ofuf),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [1:0]  ofuf;
    logic        dbz;
    int          lat;
    int          acc;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer division of the significands, truncated.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic        s;
    int          ae, be, ex;
    int unsigned mx, my, q;
    s  = a[15] ^ b[15];
    ae = int'(a[14:10]);
    be = int'(b[14:10]);
    e.a = a; e.b = b; e.ofuf = 2'b00; e.dbz = 1'b0; e.acc = 0;
    if (be == 0) begin
      e.dbz = 1'b1;
      e.res = (ae == 0) ? 16'h7E00 : {s, 15'h7C00};
      e.lat = 1;
    end else if (ae == 0) begin
      e.res = {s, 15'h0000};
      e.lat = 1;
    end else begin
      e.lat = 13;
      mx = 1024 + int'(a[9:0]);
      my = 1024 + int'(b[9:0]);
      if (mx >= my) begin
        q  = (mx * 1024) / my;
        ex = ae - be + 15;
      end else begin
        q  = (mx * 2048) / my;
        ex = ae - be + 14;
      end
      if (ex >= 31) begin
        e.ofuf = 2'b10;
        e.res  = {s, 15'h7C00};
      end else if (ex <= 0) begin
        e.ofuf = 2'b01;
        e.res  = {s, 15'h0000};
      end else begin
        e.res = {s, 5'(ex), 10'(q - 1024)};
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: result %h with empty scoreboard (t=%0t)", result, $time);
      end else begin
        e = sb.pop_front();
        check($sformatf("result %h/%h", e.a, e.b), {16'h0, result}, {16'h0, e.res});
        check($sformatf("ofuf %h/%h", e.a, e.b), {30'h0, ofuf}, {30'h0, e.ofuf});
        check($sformatf("div_by_zero %h/%h", e.a, e.b), {31'h0, div_by_zero}, {31'h0, e.dbz});
        check($sformatf("latency %h/%h", e.a, e.b), cyc - e.acc, e.lat);
        check("busy_at_done", {31'h0, busy}, 32'd1);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   guard = 0;
    while (!(busy == 1'b0 || done == 1'b1)) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL issue_wait_timeout: busy stuck for %0d cycles", guard);
        return;
      end
    end
    start = 1'b1;
    x = a;
    y = b;
    e = model(a, b);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    x = 16'($urandom);
    y = 16'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'h0, busy}, 32'd0);
    check({tag, "_done"}, {31'h0, done}, 32'd0);
    check({tag, "_result"}, {16'h0, result}, 32'd0);
    check({tag, "_ofuf"}, {30'h0, ofuf}, 32'd0);
    check({tag, "_div_by_zero"}, {31'h0, div_by_zero}, 32'd0);
  endtask

  logic [15:0] dir_x[9] = '{16'h4200, 16'h3C00, 16'hC600, 16'hC600, 16'h7800,
                            16'h0400, 16'h3C00, 16'h0000, 16'h8000};
  logic [15:0] dir_y[9] = '{16'h3E00, 16'h4200, 16'h4000, 16'hC000, 16'h0400,
                            16'h7800, 16'h0000, 16'h0000, 16'h4000};

  initial begin
    logic [15:0] ra, rb;
    reset = 1'b1;
    start = 1'b0;
    x = '0;
    y = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Directed vectors, issued back to back.
    foreach (dir_x[i]) issue(dir_x[i], dir_y[i]);
    drain();

    // Start during DIVIDE must be ignored.
    issue(16'h4200, 16'h3E00);
    repeat (4) @(negedge clk);
    start = 1'b1;
    x = 16'h3C00;
    y = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset in DIVIDE cycle 5: outputs clear at once, no done follows.
    issue(16'h3C00, 16'h4200);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("no_done_after_reset", {31'h0, done}, 32'd0);
    end
    issue(16'h4200, 16'h3E00);
    drain();

    // Randomized operands, biased toward zeros and mid-range exponents.
    repeat (300) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(9) == 0) ra[14:10] = 5'd0;
      if ($urandom_range(9) == 0) rb[14:10] = 5'd0;
      if ($urandom_range(1) == 0) begin
        ra[14:10] = 5'($urandom_range(22, 8));
        rb[14:10] = 5'($urandom_range(22, 8));
      end
      issue(ra, rb);
      repeat ($urandom_range(2)) @(negedge clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
